iter_divide: RTL

ITER_DIVIDE -- requirements
Module: iter_divide

---
 rtl/iter_divide_pkg.sv | 17 +
 rtl/iter_divide_div_step.sv | 23 ++
 rtl/iter_divide.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/iter_divide_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package iter_divide_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        CALC  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Bits needed to count WIDTH_N iterations (0 .. n-1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iter_divide_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, select.
module div_step #(
    parameter int unsigned WIDTH_D = 32
) (
    input  logic [WIDTH_D-1:0] rem_in,
    input  logic               bit_in,
    input  logic [WIDTH_D-1:0] divisor,
    output logic [WIDTH_D-1:0] rem_out,
    output logic               q_bit
);

    logic [WIDTH_D:0]   partial;
    logic [WIDTH_D+1:0] trial;

    always_comb begin
        partial = {rem_in, bit_in};
        trial   = {1'b0, partial} - {2'b00, divisor};
        // Top bit of the extended difference is the borrow.
        q_bit   = ~trial[WIDTH_D+1];
        rem_out = q_bit ? trial[WIDTH_D-1:0] : partial[WIDTH_D-1:0];
    end

endmodule

// File: rtl/iter_divide.sv
// Multi-cycle signed/unsigned divider: one quotient bit per enabled clock,
// truncating toward zero with the remainder taking the numerator's sign.
module iter_divide #(
    parameter int unsigned WIDTH_N   = 32,
    parameter int unsigned WIDTH_D   = 32,
    parameter bit          SIGNED_EN = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clken,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_N-1:0] numer,
    input  logic [WIDTH_D-1:0] denom,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remain,
    output logic               div_zero,
    output logic               overflow
);
    import iter_divide_pkg::*;

    localparam int unsigned CNT_W = cnt_width(WIDTH_N);
    localparam logic [WIDTH_N-1:0] MOST_NEG = WIDTH_N'(1) << (WIDTH_N - 1);
    localparam logic [CNT_W-1:0]   LAST_IT  = CNT_W'(WIDTH_N - 1);

    state_e             state_q, state_d;
    logic [WIDTH_N-1:0] num_raw_q, num_raw_d;
    logic [WIDTH_D-1:0] den_raw_q, den_raw_d;
    logic               sgn_q, sgn_d;
    logic               neg_n_q, neg_n_d;
    logic               neg_q_q, neg_q_d;
    logic [WIDTH_N-1:0] dvd_q, dvd_d;
    logic [WIDTH_D-1:0] dvs_q, dvs_d;
    logic [WIDTH_D-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH_N-1:0] quo_out_q, quo_out_d;
    logic [WIDTH_D-1:0] rem_out_q, rem_out_d;
    logic               dz_q, dz_d;
    logic               ov_q, ov_d;

    logic [WIDTH_D-1:0] step_rem;
    logic               step_bit;
    logic               num_neg, den_neg;

    div_step #(.WIDTH_D(WIDTH_D)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[WIDTH_N-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        state_d   = state_q;
        num_raw_d = num_raw_q;
        den_raw_d = den_raw_q;
        sgn_d     = sgn_q;
        neg_n_d   = neg_n_q;
        neg_q_d   = neg_q_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dz_d      = dz_q;
        ov_d      = ov_q;
        num_neg   = sgn_q & num_raw_q[WIDTH_N-1];
        den_neg   = sgn_q & den_raw_q[WIDTH_D-1];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    num_raw_d = numer;
                    den_raw_d = denom;
                    sgn_d     = SIGNED_EN && in_signed;
                    state_d   = PREP;
                end
            end
            PREP: begin
                if (den_raw_q == '0) begin
                    quo_out_d = '1;
                    rem_out_d = num_raw_q[WIDTH_D-1:0];
                    dz_d      = 1'b1;
                    ov_d      = 1'b0;
                    state_d   = DONE;
                end else if (sgn_q && num_raw_q == MOST_NEG && den_raw_q == '1) begin
                    quo_out_d = num_raw_q;
                    rem_out_d = '0;
                    dz_d      = 1'b0;
                    ov_d      = 1'b1;
                    state_d   = DONE;
                end else begin
                    dvd_d   = num_neg ? -num_raw_q : num_raw_q;
                    dvs_d   = den_neg ? -den_raw_q : den_raw_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    neg_n_d = num_neg;
                    neg_q_d = num_neg ^ den_neg;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Dividend register shifts out its MSB and fills with quotient bits.
                dvd_d = (dvd_q << 1) | WIDTH_N'(step_bit);
                rem_d = step_rem;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_IT) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                quo_out_d = neg_q_q ? -dvd_q : dvd_q;
                rem_out_d = neg_n_q ? -rem_q : rem_q;
                dz_d      = 1'b0;
                ov_d      = 1'b0;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            num_raw_q <= '0;
            den_raw_q <= '0;
            sgn_q     <= 1'b0;
            neg_n_q   <= 1'b0;
            neg_q_q   <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else if (clken) begin
            state_q   <= state_d;
            num_raw_q <= num_raw_d;
            den_raw_q <= den_raw_d;
            sgn_q     <= sgn_d;
            neg_n_q   <= neg_n_d;
            neg_q_q   <= neg_q_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dz_q      <= dz_d;
            ov_q      <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_out_q;
    assign remain    = rem_out_q;
    assign div_zero  = dz_q;
    assign overflow  = ov_q;

endmodule
